ch_mixer: RTL and testbench
===========================

CH_MIXER -- requirements
Module: ch_mixer

Interface
REQ-001 Parameter NUM_CH, default 2, number of resampled channels consumed.
REQ-002 Parameter NUM_CH_LOG2, default 1, ceil(log2(NUM_CH)).
REQ-003 Parameter ACK_TIMEOUT, default 64, cycles after pop_o within which acks are accepted.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 strobe_i  input  1  output-sample-rate tick, one-cycle pulse.
REQ-007 pop_o  output  NUM_CH  per-channel sample request to the resample_pipeline pop_i.
REQ-008 ack_i  input  NUM_CH  per-channel sample valid from the resample_pipeline ack_o.
REQ-009 data_i  input  24*NUM_CH  signed 24-bit samples, channel c at bits [24c+23:24c].
REQ-010 vol_i  input  16*NUM_CH  unsigned Q1.15 gain per channel; 0x8000 = unity.
REQ-011 ack_o  output  1  one-cycle pulse, mixed sample valid.
REQ-012 data_o  output  24  signed saturated mix, held until next ack_o.
REQ-013 busy_o  output  1  high whenever state is not IDLE.
REQ-014 clip_o  output  1  one-cycle pulse coincident with ack_o when saturation occurred.
REQ-015 overrun_o  output  1  sticky: strobe_i arrived while busy.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_ACK, MAC, OUT.
REQ-017 IDLE: when strobe_i=1, the block SHALL assert pop_o to all ones for exactly the next cycle, clear the ack mask and the timeout counter, and enter WAIT_ACK.
REQ-018 WAIT_ACK: an ack_i[c] with mask[c]=0 SHALL latch data_i slice c into sample register c and set mask[c]; an ack_i[c] with mask[c]=1 SHALL be ignored.
REQ-019 Acks SHALL be accepted from the cycle pop_o is high through ACK_TIMEOUT cycles after it.
REQ-020 WAIT_ACK SHALL exit to MAC in the cycle after the mask becomes all ones, or when the timeout counter reaches ACK_TIMEOUT; unacked channels SHALL contribute 0.
REQ-021 MAC SHALL process one channel per cycle, in order 0..NUM_CH-1: product = signed(sample) * unsigned(vol), 41-bit signed, arithmetic shift right 15, truncation toward minus infinity.
REQ-022 The accumulator SHALL be 26+NUM_CH_LOG2 bits signed, cleared on MAC entry, never wrapping.
REQ-023 OUT SHALL saturate the accumulator to [-0x800000, 0x7FFFFF], load data_o, pulse ack_o, pulse clip_o if clamped, then return to IDLE.
REQ-024 Latency: with all acks arriving in the cycle after pop_o, ack_o SHALL rise NUM_CH+4 cycles after strobe_i.
REQ-025 strobe_i while busy_o=1 SHALL be ignored and SHALL set overrun_o; a strobe_i in the same cycle as the return to IDLE is also ignored.
REQ-026 pop_o SHALL never be asserted outside the single cycle following an accepted strobe.

Reset
REQ-027 On rst: state=IDLE, pop_o=0, ack_o=0, clip_o=0, overrun_o=0, busy_o=0, data_o=0, mask=0, accumulator=0, sample registers=0.
REQ-028 rst asserted mid-operation SHALL abort immediately with no ack_o; the first strobe_i after deassertion SHALL start a fresh cycle.

Structure
REQ-029 State encodings, UNITY_VOL=16'h8000 and sample width 24 SHALL live in the shared dmix constants header.
REQ-030 Saturation SHALL be a sub-module sat24: combinational, parameterised input width, producing a 24-bit result plus a clip flag.
REQ-031 Sample storage SHALL be a NUM_CH-entry register array indexed by a NUM_CH_LOG2-bit MAC counter.

Verification
REQ-032 Unity gain, ch0=0x100000, ch1=0x200000, acks one cycle after pop -> data_o=0x300000, clip_o=0, ack_o at strobe+6.
REQ-033 Unity gain, ch0=ch1=0x7FFFFF -> data_o=0x7FFFFF, clip_o=1; ch0=ch1=0x800000 -> data_o=0x800000, clip_o=1.
REQ-034 vol0=0x4000, vol1=0x0000, ch0=0x400000, ch1=0x123456 -> data_o=0x200000.
REQ-035 Only ch0 acks (0x000010, unity gain) -> ack_o at pop+ACK_TIMEOUT+3, data_o=0x000010; a duplicate ch0 ack carrying 0x7FFFFF is ignored.
REQ-036 Second strobe_i during WAIT_ACK -> no extra pop_o, overrun_o=1 until rst.
REQ-037 rst pulsed during MAC -> no ack_o, all outputs zero; next strobe_i completes normally with correct sum.

Source files
------------

// File: rtl/dmix_pkg.sv
// Shared constants for the downmix datapath.
// Holds the mixer FSM state encoding, the unity gain value and the sample width.
package dmix_pkg;

    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned VOL_W     = 16;
    localparam logic [15:0] UNITY_VOL = 16'h8000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StMac     = 2'd2,
        StOut     = 2'd3
    } mix_state_t;

endpackage

// File: rtl/sat24.sv
// Saturate a signed value of parameterised width to signed 24 bits.
// Ports:
//   din_i  - signed input, IN_W bits
//   dout_o - input clamped to [-0x800000, 0x7FFFFF]
//   clip_o - high when clamping changed the value
module sat24 #(
    parameter int unsigned IN_W = 27
) (
    input  logic signed [IN_W-1:0] din_i,
    output logic [23:0]            dout_o,
    output logic                   clip_o
);

    // Bits IN_W-1 down to 23 must all match the sign for the value to fit.
    logic [IN_W-24:0] upper;

    always_comb begin
        upper  = din_i[IN_W-1:23];
        clip_o = !((&upper) || !(|upper));
        if (!clip_o) begin
            dout_o = din_i[23:0];
        end else if (din_i[IN_W-1]) begin
            dout_o = 24'h800000;
        end else begin
            dout_o = 24'h7FFFFF;
        end
    end

endmodule

// File: rtl/ch_mixer.sv
// Channel mixer: on each output-rate strobe, requests one sample from every
// resampled channel, collects the acks (with a timeout), multiplies each sample
// by its Q1.15 gain, sums the products and emits a saturated 24-bit mix.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   strobe_i   - output-rate tick
//   pop_o      - per-channel sample request, one cycle after an accepted strobe
//   ack_i      - per-channel sample valid, data on data_i slice c
//   vol_i      - per-channel unsigned Q1.15 gain
//   ack_o      - mixed sample valid pulse, data_o holds it until the next one
//   busy_o     - mixer not idle
//   clip_o     - saturation pulse alongside ack_o
//   overrun_o  - sticky: a strobe arrived while busy
module ch_mixer
    import dmix_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned NUM_CH_LOG2 = 1,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         strobe_i,
    output logic [NUM_CH-1:0]            pop_o,
    input  logic [NUM_CH-1:0]            ack_i,
    input  logic [SAMPLE_W*NUM_CH-1:0]   data_i,
    input  logic [VOL_W*NUM_CH-1:0]      vol_i,
    output logic                         ack_o,
    output logic [SAMPLE_W-1:0]          data_o,
    output logic                         busy_o,
    output logic                         clip_o,
    output logic                         overrun_o
);

    localparam int unsigned AW = 26 + NUM_CH_LOG2;
    localparam int unsigned CW = (NUM_CH_LOG2 > 0) ? NUM_CH_LOG2 : 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    mix_state_t           state_q;
    logic [NUM_CH-1:0]    mask_q;
    logic [SAMPLE_W-1:0]  samples_q [NUM_CH];
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        timer_q;
    logic signed [AW-1:0] acc_q;

    logic [SAMPLE_W-1:0]  mac_sample;
    logic [VOL_W-1:0]     mac_vol;
    logic signed [40:0]   mac_prod;
    logic signed [AW-1:0] mac_term;
    logic [SAMPLE_W-1:0]  sat_data;
    logic                 sat_clip;

    // Channels that never acked contribute zero through the mask gate.
    always_comb begin
        mac_sample = mask_q[cnt_q] ? samples_q[cnt_q] : '0;
        mac_vol    = vol_i[VOL_W*cnt_q +: VOL_W];
        mac_prod   = $signed({{17{mac_sample[SAMPLE_W-1]}}, mac_sample}) *
                     $signed({25'b0, mac_vol});
        // Arithmetic shift floors toward minus infinity.
        mac_term   = AW'(mac_prod >>> 15);
    end

    sat24 #(
        .IN_W (AW)
    ) u_sat24 (
        .din_i  (acc_q),
        .dout_o (sat_data),
        .clip_o (sat_clip)
    );

    assign busy_o = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pop_o     <= '0;
            ack_o     <= 1'b0;
            clip_o    <= 1'b0;
            overrun_o <= 1'b0;
            data_o    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            acc_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                samples_q[c] <= '0;
            end
        end else begin
            pop_o  <= '0;
            ack_o  <= 1'b0;
            clip_o <= 1'b0;
            if (strobe_i && (state_q != StIdle)) begin
                overrun_o <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (strobe_i) begin
                        pop_o   <= '1;
                        mask_q  <= '0;
                        timer_q <= '0;
                        state_q <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    // First ack per channel wins; repeats are dropped.
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ack_i[c] && !mask_q[c]) begin
                            samples_q[c] <= data_i[SAMPLE_W*c +: SAMPLE_W];
                            mask_q[c]    <= 1'b1;
                        end
                    end
                    if ((&mask_q) || (timer_q == TW'(ACK_TIMEOUT))) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StMac;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + mac_term;
                    if (cnt_q == CW'(NUM_CH - 1)) begin
                        state_q <= StOut;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StOut: begin
                    data_o  <= sat_data;
                    ack_o   <= 1'b1;
                    clip_o  <= sat_clip;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ch_mixer.sv
module tb_ch_mixer;
    import dmix_pkg::*;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned ACK_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe_i;
    logic [1:0]  pop_o;
    logic [1:0]  ack_i;
    logic [47:0] data_i;
    logic [31:0] vol_i;
    logic        ack_o;
    logic [23:0] data_o;
    logic        busy_o;
    logic        clip_o;
    logic        overrun_o;

    int errors = 0;
    int checks = 0;

    ch_mixer #(
        .NUM_CH      (NUM_CH),
        .NUM_CH_LOG2 (1),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe_i  (strobe_i),
        .pop_o     (pop_o),
        .ack_i     (ack_i),
        .data_i    (data_i),
        .vol_i     (vol_i),
        .ack_o     (ack_o),
        .data_o    (data_o),
        .busy_o    (busy_o),
        .clip_o    (clip_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [23:0] exp_data;
        logic        exp_clip;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One strobe-to-ack_o transaction. n counts rising edges after the one that
    // samples the strobe; acks are driven so the DUT samples them at edge 2.
    task automatic do_txn(input logic [23:0] d0, input logic [23:0] d1,
                          input logic [1:0] acks, input bit dup, input int strobe_at,
                          output int lat, output logic [23:0] dout, output logic clp,
                          output int pops);
        int n;
        @(negedge clk);
        strobe_i = 1'b1;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        n    = 0;
        lat  = -1;
        dout = 'x;
        clp  = 1'bx;
        pops = 0;
        if (pop_o == 2'b11) pops++;
        else if (pop_o != 2'b00) pops += 100;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (pop_o == 2'b11) pops++;
            else if (pop_o != 2'b00) pops += 100;
            if (ack_o) begin
                lat  = n;
                dout = data_o;
                clp  = clip_o;
                break;
            end
            ack_i    = 2'b00;
            strobe_i = 1'b0;
            if (n == 1) begin
                ack_i  = acks;
                data_i = {d1, d0};
            end
            if (n == 2 && dup) begin
                ack_i        = 2'b01;
                data_i[23:0] = 24'h7FFFFF;
            end
            if (n == strobe_at) strobe_i = 1'b1;
        end
        ack_i    = 2'b00;
        strobe_i = 1'b0;
    endtask

    initial begin
        int          lat;
        int          pops;
        logic [23:0] dout;
        logic        clp;
        logic        got_ack;

        vecs[0] = '{24'h100000, 24'h200000, UNITY_VOL, UNITY_VOL, 24'h300000, 1'b0};
        vecs[1] = '{24'h7FFFFF, 24'h7FFFFF, UNITY_VOL, UNITY_VOL, 24'h7FFFFF, 1'b1};
        vecs[2] = '{24'h800000, 24'h800000, UNITY_VOL, UNITY_VOL, 24'h800000, 1'b1};
        vecs[3] = '{24'h400000, 24'h123456, 16'h4000,  16'h0000,  24'h200000, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'h000000, 16'h4000,  16'h0000,  24'hFFFFFF, 1'b0};
        vecs[5] = '{24'h000003, 24'hFFFFFD, 16'h4000,  16'h4000,  24'hFFFFFF, 1'b0};
        vecs[6] = '{24'h400000, 24'h000000, 16'hFFFF,  16'h0000,  24'h7FFF80, 1'b0};
        vecs[7] = '{24'h800000, 24'h800000, 16'hFFFF,  16'hFFFF,  24'h800000, 1'b1};
        vecs[8] = '{24'h7FFFFF, 24'h800000, UNITY_VOL, UNITY_VOL, 24'hFFFFFF, 1'b0};
        vecs[9] = '{24'h400000, 24'h3FFFFF, UNITY_VOL, UNITY_VOL, 24'h7FFFFF, 1'b0};

        rst      = 1'b1;
        strobe_i = 1'b0;
        ack_i    = 2'b00;
        data_i   = '0;
        vol_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", {30'b0, pop_o}, 0);
        chk("rst_ack", {31'b0, ack_o}, 0);
        chk("rst_data", {8'b0, data_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_clip", {31'b0, clip_o}, 0);
        chk("rst_overrun", {31'b0, overrun_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            vol_i = {vecs[i].v1, vecs[i].v0};
            do_txn(vecs[i].d0, vecs[i].d1, 2'b11, 1'b0, 0, lat, dout, clp, pops);
            chk($sformatf("v%0d_data", i), {8'b0, dout}, {8'b0, vecs[i].exp_data});
            chk($sformatf("v%0d_clip", i), {31'b0, clp}, {31'b0, vecs[i].exp_clip});
            chk($sformatf("v%0d_latency", i), lat, NUM_CH + 4);
            chk($sformatf("v%0d_pops", i), pops, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ack_pulse", i), {31'b0, ack_o}, 0);
            chk($sformatf("v%0d_idle", i), {31'b0, busy_o}, 0);
        end
        chk("no_overrun_yet", {31'b0, overrun_o}, 0);

        // Only ch0 acks; a repeat ch0 ack with a large value must be ignored.
        vol_i = {UNITY_VOL, UNITY_VOL};
        do_txn(24'h000010, 24'h555555, 2'b01, 1'b1, 0, lat, dout, clp, pops);
        chk("tmo_data", {8'b0, dout}, 32'h10);
        chk("tmo_clip", {31'b0, clp}, 0);
        chk("tmo_latency", lat, ACK_TIMEOUT + 4);
        chk("tmo_pops", pops, 1);

        // Extra strobe while waiting for acks.
        do_txn(24'h000100, 24'h000200, 2'b11, 1'b0, 1, lat, dout, clp, pops);
        chk("ovr_pops", pops, 1);
        chk("ovr_data", {8'b0, dout}, 32'h300);
        chk("ovr_flag", {31'b0, overrun_o}, 1);
        do_txn(24'h000001, 24'h000002, 2'b11, 1'b0, 0, lat, dout, clp, pops);
        chk("ovr_sticky", {31'b0, overrun_o}, 1);
        chk("ovr_next_data", {8'b0, dout}, 32'h3);

        // Reset in the middle of the MAC phase.
        @(negedge clk);
        strobe_i = 1'b1;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        @(posedge clk);
        #1;
        ack_i  = 2'b11;
        data_i = {24'h000456, 24'h000123};
        @(posedge clk);
        #1;
        ack_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("mac_busy", {31'b0, busy_o}, 1);
        rst = 1'b1;
        #2;
        chk("abort_ack", {31'b0, ack_o}, 0);
        chk("abort_data", {8'b0, data_o}, 0);
        chk("abort_busy", {31'b0, busy_o}, 0);
        chk("abort_overrun", {31'b0, overrun_o}, 0);
        chk("abort_pop", {30'b0, pop_o}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_ack = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack_o) got_ack = 1'b1;
        end
        chk("abort_no_ack", {31'b0, got_ack}, 0);
        do_txn(24'h000123, 24'h000456, 2'b11, 1'b0, 0, lat, dout, clp, pops);
        chk("post_rst_data", {8'b0, dout}, 32'h579);
        chk("post_rst_latency", lat, NUM_CH + 4);
        chk("post_rst_pops", pops, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
